// File: rtl/osd_him_host.sv
// Host-side endpoint of the OSD host interface link.
// TX: buffers a whole DII packet, then sends a length word followed by the flits.
// RX: checks an incoming length word, then passes the flits straight through to DII.
// Both directions keep a wrapping 16-bit packet counter for link debug.
//
// TX states
//   state        | meaning
//   TX_FILL      | collecting flits into the packet buffer
//   TX_DROP      | packet grew past MAX_PKT_LEN, discarding until last
//   TX_SEND_LEN  | presenting the length word on glip_out
//   TX_SEND_DATA | presenting buffered flits on glip_out
// RX states
//   state        | meaning
//   RX_IDLE      | waiting for a length word
//   RX_DATA      | forwarding flits, remain = flits left after the current one
module osd_him_host #(
   parameter int MAX_PKT_LEN = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] dii_in_data,
   input  logic        dii_in_valid,
   input  logic        dii_in_last,
   output logic        dii_in_ready,
   output logic [15:0] glip_out_data,
   output logic        glip_out_valid,
   input  logic        glip_out_ready,
   input  logic [15:0] glip_in_data,
   input  logic        glip_in_valid,
   output logic        glip_in_ready,
   output logic [15:0] dii_out_data,
   output logic        dii_out_valid,
   output logic        dii_out_last,
   input  logic        dii_out_ready,
   output logic        err_len,
   output logic        err_ovf,
   output logic [15:0] tx_pkt_cnt,
   output logic [15:0] rx_pkt_cnt
);

   localparam logic [4:0] MAX_L = 5'(MAX_PKT_LEN);
   // Buffer depth rounded up to a power of two so the write/read pointers index it exactly.
   localparam int AW = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;

   typedef enum logic [1:0] {TX_FILL, TX_DROP, TX_SEND_LEN, TX_SEND_DATA} tx_state_t;
   typedef enum logic {RX_IDLE, RX_DATA} rx_state_t;

   tx_state_t   tx_state, tx_next;
   rx_state_t   rx_state, rx_next;
   logic [15:0] pkt_buf [0:(2**AW)-1];
   logic [4:0]  wcnt, rd, n_len, remain;
   logic        tx_accept, tx_done, ovf_det;
   logic        len_ok, len_bad, rx_hs, rx_done;

   // TX state register
   always_ff @(posedge clk) begin
      if (rst) tx_state <= TX_FILL;
      else     tx_state <= tx_next;
   end

   // TX next-state and handshake outputs
   always_comb begin
      tx_next        = tx_state;
      dii_in_ready   = 1'b0;
      glip_out_valid = 1'b0;
      glip_out_data  = '0;
      tx_accept      = 1'b0;
      tx_done        = 1'b0;
      ovf_det        = 1'b0;
      case (tx_state)
         TX_FILL: begin
            dii_in_ready = 1'b1;
            tx_accept    = dii_in_valid;
            if (dii_in_valid) begin
               if (dii_in_last)                tx_next = TX_SEND_LEN;
               else if (wcnt + 5'd1 == MAX_L) tx_next = TX_DROP;
            end
         end
         TX_DROP: begin
            dii_in_ready = 1'b1;
            if (dii_in_valid && dii_in_last) begin
               ovf_det = 1'b1;
               tx_next = TX_FILL;
            end
         end
         TX_SEND_LEN: begin
            glip_out_valid = 1'b1;
            glip_out_data  = {11'b0, n_len};
            if (glip_out_ready) tx_next = TX_SEND_DATA;
         end
         TX_SEND_DATA: begin
            glip_out_valid = 1'b1;
            glip_out_data  = pkt_buf[rd[AW-1:0]];
            if (glip_out_ready && (rd == n_len - 5'd1)) begin
               tx_done = 1'b1;
               tx_next = TX_FILL;
            end
         end
         default: tx_next = TX_FILL;
      endcase
   end

   // Packet buffer write; contents need no reset since wcnt/n_len gate every read
   always_ff @(posedge clk) begin
      if (tx_accept) pkt_buf[wcnt[AW-1:0]] <= dii_in_data;
   end

   // TX counters, length capture and overflow pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt       <= '0;
         rd         <= '0;
         n_len      <= '0;
         err_ovf    <= 1'b0;
         tx_pkt_cnt <= '0;
      end else begin
         err_ovf <= ovf_det;
         if (tx_accept) begin
            wcnt <= wcnt + 5'd1;
            if (dii_in_last) n_len <= wcnt + 5'd1;
         end
         if (ovf_det || tx_done) wcnt <= '0;
         if (tx_state == TX_SEND_LEN && glip_out_ready)       rd <= '0;
         else if (tx_state == TX_SEND_DATA && glip_out_ready) rd <= rd + 5'd1;
         if (tx_done) tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
      end
   end

   assign len_ok = (glip_in_data[15:5] == 11'd0) && (glip_in_data[4:0] != 5'd0) &&
                   (glip_in_data[4:0] <= MAX_L);

   // RX state register
   always_ff @(posedge clk) begin
      if (rst) rx_state <= RX_IDLE;
      else     rx_state <= rx_next;
   end

   // RX next-state and cut-through data path
   always_comb begin
      rx_next       = rx_state;
      glip_in_ready = 1'b0;
      dii_out_valid = 1'b0;
      dii_out_last  = 1'b0;
      dii_out_data  = glip_in_data;
      len_bad       = 1'b0;
      rx_hs         = 1'b0;
      rx_done       = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            glip_in_ready = 1'b1;
            if (glip_in_valid) begin
               if (len_ok) rx_next = RX_DATA;
               else        len_bad = 1'b1;
            end
         end
         RX_DATA: begin
            glip_in_ready = dii_out_ready;
            dii_out_valid = glip_in_valid;
            dii_out_last  = (remain == 5'd0);
            rx_hs         = glip_in_valid && dii_out_ready;
            if (rx_hs && remain == 5'd0) begin
               rx_done = 1'b1;
               rx_next = RX_IDLE;
            end
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   // RX remaining-flit counter, length error pulse and packet counter
   always_ff @(posedge clk) begin
      if (rst) begin
         remain     <= '0;
         err_len    <= 1'b0;
         rx_pkt_cnt <= '0;
      end else begin
         err_len <= len_bad;
         if (rx_state == RX_IDLE && glip_in_valid && len_ok) remain <= glip_in_data[4:0] - 5'd1;
         else if (rx_hs && remain != 5'd0)                   remain <= remain - 5'd1;
         if (rx_done) rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_osd_him_host.sv
// Scoreboard bench for osd_him_host: expected glip_out words and dii_out flits are
// queued as stimulus is driven and popped when the DUT hands them over.
module tb_osd_him_host;
   localparam int MAX = 12;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] dii_in_data = '0;
   logic        dii_in_valid = 1'b0;
   logic        dii_in_last = 1'b0;
   logic        dii_in_ready;
   logic [15:0] glip_out_data;
   logic        glip_out_valid;
   logic        glip_out_ready = 1'b1;
   logic [15:0] glip_in_data = '0;
   logic        glip_in_valid = 1'b0;
   logic        glip_in_ready;
   logic [15:0] dii_out_data;
   logic        dii_out_valid;
   logic        dii_out_last;
   logic        dii_out_ready = 1'b1;
   logic        err_len, err_ovf;
   logic [15:0] tx_pkt_cnt, rx_pkt_cnt;

   osd_him_host #(.MAX_PKT_LEN(MAX)) dut (
      .clk(clk), .rst(rst),
      .dii_in_data(dii_in_data), .dii_in_valid(dii_in_valid), .dii_in_last(dii_in_last),
      .dii_in_ready(dii_in_ready),
      .glip_out_data(glip_out_data), .glip_out_valid(glip_out_valid),
      .glip_out_ready(glip_out_ready),
      .glip_in_data(glip_in_data), .glip_in_valid(glip_in_valid), .glip_in_ready(glip_in_ready),
      .dii_out_data(dii_out_data), .dii_out_valid(dii_out_valid), .dii_out_last(dii_out_last),
      .dii_out_ready(dii_out_ready),
      .err_len(err_len), .err_ovf(err_ovf),
      .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] tx_q [$];
   logic [16:0] rx_q [$];
   int          exp_tx = 0, exp_rx = 0, exp_ovf = 0, exp_len = 0;
   int          ovf_seen = 0, len_seen = 0;
   int          gor_mode = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // glip_out.ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = held low
   initial begin
      forever begin
         @(posedge clk); #1;
         case (gor_mode)
            0:       glip_out_ready = 1'b1;
            1:       glip_out_ready = ~glip_out_ready;
            default: glip_out_ready = 1'b0;
         endcase
      end
   end

   // Output monitors: pop on handshake, compare held data while stalled
   always @(negedge clk) begin
      if (!rst) begin
         if (err_ovf) ovf_seen++;
         if (err_len) len_seen++;
         if (glip_out_valid) begin
            chk("tx_busy_rdy", 32'(dii_in_ready), 32'd0);
            if (tx_q.size() == 0)    chk("tx_unexpected", tx_q.size(), 1);
            else if (glip_out_ready) chk("tx_word", 32'(glip_out_data), 32'(tx_q.pop_front()));
            else                     chk("tx_stall", 32'(glip_out_data), 32'(tx_q[0]));
         end
         if (dii_out_valid) begin
            if (rx_q.size() == 0)   chk("rx_unexpected", rx_q.size(), 1);
            else if (dii_out_ready) chk("rx_flit", {15'd0, dii_out_data, dii_out_last},
                                        32'(rx_q.pop_front()));
            else                    chk("rx_stall", {15'd0, dii_out_data, dii_out_last},
                                        32'(rx_q[0]));
         end
      end
   end

   task automatic dii_put(input logic [15:0] d, input logic l);
      logic ok;
      ok = 1'b0;
      dii_in_data = d; dii_in_last = l; dii_in_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk); ok = dii_in_ready;
         @(posedge clk); #1;
      end
      dii_in_valid = 1'b0;
      if (!ok) chk("dii_in_timeout", 32'(ok), 32'd1);
   endtask

   task automatic glip_put(input logic [15:0] w);
      logic ok;
      ok = 1'b0;
      glip_in_data = w; glip_in_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk); ok = glip_in_ready;
         @(posedge clk); #1;
      end
      glip_in_valid = 1'b0;
      if (!ok) chk("glip_in_timeout", 32'(ok), 32'd1);
   endtask

   task automatic tx_pkt(input int n, input logic [15:0] base, input logic [15:0] step);
      if (n <= MAX) begin
         tx_q.push_back(16'(n));
         for (int i = 0; i < n; i++) tx_q.push_back(base + step * 16'(i));
         exp_tx++;
      end else begin
         exp_ovf++;
      end
      for (int i = 0; i < n; i++) dii_put(base + step * 16'(i), i == n - 1);
   endtask

   task automatic rx_pkt(input int n, input logic [15:0] base, input logic [15:0] step);
      logic [15:0] d;
      for (int i = 0; i < n; i++) begin
         d = base + step * 16'(i);
         rx_q.push_back({d, i == n - 1});
      end
      exp_rx++;
      glip_put(16'(n));
      for (int i = 0; i < n; i++) glip_put(base + step * 16'(i));
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (tx_q.size() == 0 && rx_q.size() == 0) break;
      end
      chk("drain", tx_q.size() + rx_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_gout_valid", 32'(glip_out_valid), 0);
      chk("rst_dout_valid", 32'(dii_out_valid), 0);
      chk("rst_errs", {30'd0, err_len, err_ovf}, 0);
      chk("rst_tx_cnt", 32'(tx_pkt_cnt), 0);
      chk("rst_rx_cnt", 32'(rx_pkt_cnt), 0);
      chk("rst_din_rdy", 32'(dii_in_ready), 1);
      chk("rst_gin_rdy", 32'(glip_in_ready), 1);
      @(posedge clk); #1;

      // TX basic and with backpressure
      tx_pkt(3, 16'h1111, 16'h1111);
      wait_drain();
      chk("tx_cnt_basic", 32'(tx_pkt_cnt), 32'(exp_tx));
      gor_mode = 1;
      tx_pkt(3, 16'h1111, 16'h1111);
      wait_drain();
      gor_mode = 0;
      chk("tx_cnt_bp", 32'(tx_pkt_cnt), 32'(exp_tx));

      // TX oversize, recovery, and full-size boundary
      tx_pkt(13, 16'h0100, 16'h0001);
      wait_drain();
      chk("ovf_pulses", 32'(ovf_seen), 32'(exp_ovf));
      tx_pkt(2, 16'hA000, 16'h0001);
      tx_pkt(MAX, 16'h0C00, 16'h0003);
      tx_pkt(1, 16'h7777, 16'h0000);
      wait_drain();
      chk("tx_cnt_after_ovf", 32'(tx_pkt_cnt), 32'(exp_tx));

      // RX basic, illegal lengths, single flit, max length with backpressure
      rx_pkt(2, 16'hABCD, 16'h6667);
      wait_drain();
      chk("rx_cnt_basic", 32'(rx_pkt_cnt), 32'(exp_rx));
      glip_put(16'h0000); glip_put(16'h000D); glip_put(16'h0101);
      exp_len += 3;
      rx_pkt(1, 16'h5555, 16'h0000);
      wait_drain();
      chk("len_pulses", 32'(len_seen), 32'(exp_len));
      chk("rx_cnt_illegal", 32'(rx_pkt_cnt), 32'(exp_rx));
      fork
         rx_pkt(MAX, 16'h2000, 16'h0101);
         begin
            for (int i = 0; i < 16; i++) begin
               @(posedge clk); #1 dii_out_ready = ~dii_out_ready;
            end
            dii_out_ready = 1'b1;
         end
      join
      wait_drain();
      chk("rx_cnt_bp", 32'(rx_pkt_cnt), 32'(exp_rx));

      // Concurrent traffic, then reset in the middle of a TX frame
      gor_mode = 2;
      @(posedge clk); #1;
      fork
         tx_pkt(4, 16'hB000, 16'h0001);
         rx_pkt(3, 16'hC000, 16'h0001);
      join
      for (int i = 0; i < 50 && rx_q.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk("rx_concurrent_q", rx_q.size(), 0);
      chk("rx_cnt_concurrent", 32'(rx_pkt_cnt), 32'(exp_rx));
      chk("tx_held_valid", 32'(glip_out_valid), 1);
      gor_mode = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      tx_q.delete(); rx_q.delete();
      exp_tx = 0; exp_rx = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst2_gout_valid", 32'(glip_out_valid), 0);
      chk("rst2_tx_cnt", 32'(tx_pkt_cnt), 0);
      chk("rst2_rx_cnt", 32'(rx_pkt_cnt), 0);
      chk("rst2_din_rdy", 32'(dii_in_ready), 1);
      chk("rst2_gin_rdy", 32'(glip_in_ready), 1);
      @(posedge clk); #1;
      tx_pkt(2, 16'hE000, 16'h0010);
      wait_drain();
      chk("tx_cnt_after_rst", 32'(tx_pkt_cnt), 32'(exp_tx));
      chk("ovf_total", 32'(ovf_seen), 32'(exp_ovf));
      chk("len_total", 32'(len_seen), 32'(exp_len));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
